// File: rtl/min_cost_tracker.sv
// rtl/min_cost_tracker.sv - sums N_ITEM cost words per candidate and tracks the minimum sum and how many candidates hit it
module min_cost_tracker #(
    parameter int COST_W = 7,
    parameter int N_ITEM = 8,
    parameter int SUM_W  = 10,
    parameter int CNT_W  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              clear,
    input  logic              start,
    input  logic              cost_valid,
    input  logic [COST_W-1:0] Cost,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  MatchCount
);

    localparam int IDX_W = (N_ITEM > 1) ? $clog2(N_ITEM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ITEM - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_CMP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SUM_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             minv_q, minv_d;

    logic [SUM_W:0]   acc_sum;
    logic [SUM_W-1:0] acc_sat;
    logic [CNT_W-1:0] cnt_inc;

    // One extra carry bit detects overflow so the accumulator clamps instead of wrapping.
    assign acc_sum = {1'b0, acc_q} + (SUM_W+1)'(Cost);
    assign acc_sat = acc_sum[SUM_W] ? {SUM_W{1'b1}} : acc_sum[SUM_W-1:0];
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        min_d   = min_q;
        cnt_d   = cnt_q;
        minv_d  = minv_q;
        if (clear) begin
            state_d = S_IDLE;
            acc_d   = '0;
            idx_d   = '0;
            min_d   = {SUM_W{1'b1}};
            cnt_d   = '0;
            minv_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = S_ACC;
                    end
                end
                S_ACC: begin
                    if (cost_valid) begin
                        acc_d = acc_sat;
                        idx_d = idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            state_d = S_CMP;
                        end
                    end
                end
                S_CMP: begin
                    // min_valid forces the first candidate to load even an all-ones sum.
                    if (!minv_q || (acc_q < min_q)) begin
                        min_d  = acc_q;
                        cnt_d  = CNT_W'(1);
                        minv_d = 1'b1;
                    end else if (acc_q == min_q) begin
                        cnt_d = cnt_inc;
                    end
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            min_q   <= {SUM_W{1'b1}};
            cnt_q   <= '0;
            minv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            min_q   <= min_d;
            cnt_q   <= cnt_d;
            minv_q  <= minv_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign MinCost    = min_q;
    assign MatchCount = cnt_q;

endmodule

// File: tb/tb_min_cost_tracker.sv
// tb/tb_min_cost_tracker.sv - scoreboard bench for min_cost_tracker across three parameterisations
module tb_min_cost_tracker;

    typedef struct {
        logic [9:0] mn;
        logic [3:0] cnt;
        int         t0;
        int         lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    // legacy instance: N_ITEM=1
    logic l_clear = 0, l_start = 0, l_valid = 0, l_busy, l_done;
    logic [6:0] l_cost = 0;
    logic [9:0] l_min;
    logic [3:0] l_cnt;
    // standard instance: N_ITEM=8
    logic s_clear = 0, s_start = 0, s_valid = 0, s_busy, s_done;
    logic [6:0] s_cost = 0;
    logic [9:0] s_min;
    logic [3:0] s_cnt;
    // saturation instance: SUM_W=8, N_ITEM=4
    logic t_clear = 0, t_start = 0, t_valid = 0, t_busy, t_done;
    logic [6:0] t_cost = 0;
    logic [7:0] t_min;
    logic [3:0] t_cnt;

    exp_t l_q[$];
    exp_t s_q[$];
    exp_t t_q[$];

    min_cost_tracker #(.COST_W(7), .N_ITEM(1), .SUM_W(10), .CNT_W(4)) u_leg (
        .CLK(CLK), .RST(RST), .clear(l_clear), .start(l_start), .cost_valid(l_valid),
        .Cost(l_cost), .busy(l_busy), .done(l_done), .MinCost(l_min), .MatchCount(l_cnt));

    min_cost_tracker #(.COST_W(7), .N_ITEM(8), .SUM_W(10), .CNT_W(4)) u_std (
        .CLK(CLK), .RST(RST), .clear(s_clear), .start(s_start), .cost_valid(s_valid),
        .Cost(s_cost), .busy(s_busy), .done(s_done), .MinCost(s_min), .MatchCount(s_cnt));

    min_cost_tracker #(.COST_W(7), .N_ITEM(4), .SUM_W(8), .CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .clear(t_clear), .start(t_start), .cost_valid(t_valid),
        .Cost(t_cost), .busy(t_busy), .done(t_done), .MinCost(t_min), .MatchCount(t_cnt));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin : mon_leg
        exp_t e;
        if (l_done) begin
            if (l_q.size() == 0) check("leg_unexpected_done", 1, 0);
            else begin
                e = l_q.pop_front();
                check("leg_min", 32'(l_min), 32'(e.mn));
                check("leg_cnt", 32'(l_cnt), 32'(e.cnt));
                check("leg_latency", cyc - e.t0, e.lat);
            end
        end
    end

    always @(negedge CLK) begin : mon_std
        exp_t e;
        if (s_done) begin
            if (s_q.size() == 0) check("std_unexpected_done", 1, 0);
            else begin
                e = s_q.pop_front();
                check("std_min", 32'(s_min), 32'(e.mn));
                check("std_cnt", 32'(s_cnt), 32'(e.cnt));
                check("std_latency", cyc - e.t0, e.lat);
            end
        end
    end

    always @(negedge CLK) begin : mon_sat
        exp_t e;
        if (t_done) begin
            if (t_q.size() == 0) check("sat_unexpected_done", 1, 0);
            else begin
                e = t_q.pop_front();
                check("sat_min", 32'(t_min), 32'(e.mn));
                check("sat_cnt", 32'(t_cnt), 32'(e.cnt));
                check("sat_latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (!l_busy && !s_busy && !t_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic leg_cand(input logic [6:0] c, input logic [9:0] emin, input logic [3:0] ecnt);
        @(posedge CLK); #1;
        l_start = 1;
        l_q.push_back('{emin, ecnt, cyc, 3});
        @(posedge CLK); #1;
        l_start = 0; l_valid = 1; l_cost = c;
        @(posedge CLK); #1;
        l_valid = 0;
        wait_idle();
    endtask

    task automatic std_cand(input int base, input int step, input int stall, input bit poke,
                            input bit push, input logic [9:0] emin, input logic [3:0] ecnt, input int elat);
        @(posedge CLK); #1;
        s_start = 1;
        if (push) s_q.push_back('{emin, ecnt, cyc, elat});
        @(posedge CLK); #1;
        s_start = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                for (int k = 0; k < stall; k++) begin
                    s_valid = 0;
                    @(posedge CLK); #1;
                end
            end
            s_valid = 1;
            s_cost  = 7'(base + i * step);
            s_start = poke && (i == 3);
            @(posedge CLK); #1;
        end
        s_valid = 0;
        s_start = 0;
        wait_idle();
    endtask

    task automatic t_cand(input logic [9:0] emin, input logic [3:0] ecnt);
        @(posedge CLK); #1;
        t_start = 1;
        t_q.push_back('{emin, ecnt, cyc, 6});
        @(posedge CLK); #1;
        t_start = 0;
        for (int i = 0; i < 4; i++) begin
            t_valid = 1; t_cost = 7'd127;
            @(posedge CLK); #1;
        end
        t_valid = 0;
        wait_idle();
    endtask

    initial begin
        logic [6:0] leg_cost [8] = '{7'd50, 7'd45, 7'd40, 7'd35, 7'd30, 7'd50, 7'd30, 7'd30};
        logic [9:0] leg_min  [8] = '{10'd50, 10'd45, 10'd40, 10'd35, 10'd30, 10'd30, 10'd30, 10'd30};
        logic [3:0] leg_cnt  [8] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3};

        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 32'(s_busy), 0);
        check("rst_done", 32'(s_done), 0);
        check("rst_min", 32'(s_min), 1023);
        check("rst_cnt", 32'(s_cnt), 0);
        check("rst_sat_min", 32'(t_min), 255);
        RST = 0;

        for (int i = 0; i < 8; i++) leg_cand(leg_cost[i], leg_min[i], leg_cnt[i]);
        check("leg_final_min", 32'(l_min), 30);
        check("leg_final_cnt", 32'(l_cnt), 3);

        @(posedge CLK); #1;
        l_clear = 1; l_start = 1;
        @(posedge CLK); #1;
        l_clear = 0; l_start = 0;
        @(posedge CLK); #1;
        check("leg_clear_start_busy", 32'(l_busy), 0);
        check("leg_clear_min", 32'(l_min), 1023);
        check("leg_clear_cnt", 32'(l_cnt), 0);
        for (int i = 0; i < 17; i++) leg_cand(7'd20, 10'd20, 4'((i + 1 > 15) ? 15 : i + 1));
        check("leg_sat_cnt", 32'(l_cnt), 15);

        @(posedge CLK); #1;
        s_valid = 1; s_cost = 7'd99;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        s_valid = 0;
        check("std_idle_valid_busy", 32'(s_busy), 0);
        std_cand(5, 0, 0, 0, 1, 10'd40, 4'd1, 10);
        std_cand(4, 0, 0, 1, 1, 10'd32, 4'd1, 10);

        @(posedge CLK); #1;
        s_clear = 1;
        @(posedge CLK); #1;
        s_clear = 0;
        std_cand(1, 1, 3, 0, 1, 10'd36, 4'd1, 13);

        @(posedge CLK); #1;
        s_start = 1;
        @(posedge CLK); #1;
        s_start = 0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_cost = 7'd1;
            @(posedge CLK); #1;
        end
        s_valid = 0; s_clear = 1;
        @(posedge CLK); #1;
        s_clear = 0;
        check("abort_busy", 32'(s_busy), 0);
        check("abort_min", 32'(s_min), 1023);
        check("abort_cnt", 32'(s_cnt), 0);
        repeat (12) @(posedge CLK);
        #1;
        std_cand(1, 0, 0, 0, 1, 10'd8, 4'd1, 10);

        t_cand(10'd255, 4'd1);
        t_cand(10'd255, 4'd2);

        @(posedge CLK); #1;
        s_start = 1;
        @(posedge CLK); #1;
        s_start = 0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1; s_cost = 7'd3;
            @(posedge CLK); #1;
        end
        RST = 1;
        #2;
        check("rst_mid_busy", 32'(s_busy), 0);
        check("rst_mid_done", 32'(s_done), 0);
        check("rst_mid_min", 32'(s_min), 1023);
        check("rst_mid_cnt", 32'(s_cnt), 0);
        s_valid = 0;
        @(posedge CLK); #1;
        RST = 0;
        repeat (12) @(posedge CLK);
        #1;
        check("rst_mid_still_idle", 32'(s_busy), 0);

        check("leg_pending", l_q.size(), 0);
        check("std_pending", s_q.size(), 0);
        check("sat_pending", t_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
